// File: rtl/cnn_pkg.sv
// cnn_pkg: shared CNN geometry, feature width and signed max helper.
// Used by the conv result receive path (maxpool2x2_stream, pool_line_buf).
package cnn_pkg;

  localparam int CONV1_OUT_W = 24;
  localparam int CONV1_OUT_H = 24;
  localparam int DATA_WIDTH  = 32;

  typedef logic signed [DATA_WIDTH-1:0] feat_t;

  // Two's-complement max; on a tie either operand is the same value.
  function automatic feat_t smax(input feat_t a, input feat_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// pool_line_buf: single-port DEPTH x DW register array, comb read.
// Ports: clk, i_we, i_idx (write/read index), i_wdata, o_rdata.
module pool_line_buf #(
  parameter int DEPTH = 12,
  parameter int DW    = 32,
  parameter int IW    = 4
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [IW-1:0] i_idx,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata
);

  // No reset: every even row rewrites all used entries before any read.
  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_idx] <= i_wdata;
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/maxpool2x2_stream.sv
// maxpool2x2_stream: raster 2x2 / stride-2 signed max-pool, no backpressure.
// Ports: clk, rst (async high), valid_in/data_in in; data_out/valid_out/frame_done out.
module maxpool2x2_stream
  import cnn_pkg::*;
#(
  parameter int IN_W       = CONV1_OUT_W,
  parameter int IN_H       = CONV1_OUT_H,
  parameter int DATA_WIDTH = cnn_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  frame_done
);

  localparam int CW    = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam int RW    = (IN_H > 1) ? $clog2(IN_H) : 1;
  localparam int DEPTH = (IN_W / 2 > 0) ? IN_W / 2 : 1;
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CW-1:0]         r_col;
  logic [RW-1:0]         r_row;
  logic [DATA_WIDTH-1:0] r_pair;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_vout;
  logic                  r_fdone;

  logic                  w_col_last;
  logic                  w_row_last;
  logic                  w_pair_en;
  logic                  w_wr;
  logic                  w_out;
  logic [IW-1:0]         w_idx;
  logic [DATA_WIDTH-1:0] w_rd;
  logic [DATA_WIDTH-1:0] w_hmax;
  logic [DATA_WIDTH-1:0] w_vmax;

  assign w_col_last = (r_col == CW'(IN_W - 1));
  assign w_row_last = (r_row == RW'(IN_H - 1));

  // With an odd width the last column is even and never pairs;
  // with an odd height the last row is even and never feeds an output.
  assign w_pair_en = valid_in & ~r_col[0] & ~w_col_last;
  assign w_wr      = valid_in &  r_col[0] & ~r_row[0] & ~w_row_last;
  assign w_out     = valid_in &  r_col[0] &  r_row[0];

  assign w_idx  = IW'(r_col >> 1);
  assign w_hmax = smax(r_pair, data_in);
  assign w_vmax = smax(w_hmax, w_rd);

  pool_line_buf #(
    .DEPTH (DEPTH),
    .DW    (DATA_WIDTH),
    .IW    (IW)
  ) u_lbuf (
    .clk     (clk),
    .i_we    (w_wr),
    .i_idx   (w_idx),
    .i_wdata (w_hmax),
    .o_rdata (w_rd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col   <= '0;
      r_row   <= '0;
      r_pair  <= '0;
      r_dout  <= '0;
      r_vout  <= 1'b0;
      r_fdone <= 1'b0;
    end else begin
      r_vout  <= w_out;
      r_fdone <= valid_in & w_col_last & w_row_last;
      if (valid_in) begin
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
      if (w_pair_en) r_pair <= data_in;
      if (w_out)     r_dout <= w_vmax;
    end
  end

  assign data_out   = r_dout;
  assign valid_out  = r_vout;
  assign frame_done = r_fdone;

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// tb_maxpool2x2_stream: scoreboard bench, 24x24 and 5x5 instances.
// Golden values come from a software 2x2 max-pool of the driven image.
module tb_maxpool2x2_stream;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               vin_a = 1'b0;
  logic               vin_b = 1'b0;
  logic signed [31:0] din = '0;
  logic        [31:0] dout_a, dout_b;
  logic               vout_a, vout_b;
  logic               fd_a, fd_b;

  int n_tests = 0;
  int n_fail  = 0;
  int n_out   = 0;

  logic signed [31:0] img [24][24];
  logic signed [31:0] sb_q [$];

  always #5 clk = ~clk;

  maxpool2x2_stream u_a (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (vin_a),
    .data_in    (din),
    .data_out   (dout_a),
    .valid_out  (vout_a),
    .frame_done (fd_a)
  );

  maxpool2x2_stream #(.IN_W(5), .IN_H(5)) u_b (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (vin_b),
    .data_in    (din),
    .data_out   (dout_b),
    .valid_out  (vout_b),
    .frame_done (fd_b)
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic idle();
    vin_a = 1'b0;
    vin_b = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_vout_a", vout_a, 0);
    chk("idle_vout_b", vout_b, 0);
  endtask

  task automatic px(input bit sel, input logic signed [31:0] d,
                    input bit trig, input logic signed [31:0] e,
                    input bit last);
    logic               vo, fd;
    logic signed [31:0] dq;
    din   = d;
    vin_a = !sel;
    vin_b = sel;
    if (trig) sb_q.push_back(e);
    @(posedge clk);
    #1;
    vin_a = 1'b0;
    vin_b = 1'b0;
    vo = sel ? vout_b : vout_a;
    fd = sel ? fd_b : fd_a;
    dq = sel ? dout_b : dout_a;
    chk("vout", vo, trig);
    chk("fdone", fd, last);
    if (vo) begin
      n_out++;
      if (sb_q.size() == 0) chk("sb_empty", 1, 0);
      else chk("data", dq, sb_q.pop_front());
    end
  endtask

  function automatic logic signed [31:0] gold(input int r, input int c);
    logic signed [31:0] m;
    m = img[r-1][c-1];
    if (img[r-1][c] > m) m = img[r-1][c];
    if (img[r][c-1] > m) m = img[r][c-1];
    if (img[r][c]   > m) m = img[r][c];
    return m;
  endfunction

  // mode 0 ramp, 1 negative ramp, 2 random; stop >= 0 aborts after stop pixels
  task automatic run_frame(input bit sel, input int w, input int h,
                           input int mode, input int gap, input int stop);
    int  n = 0;
    bit  trig;
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        case (mode)
          0: img[r][c] = r * w + c;
          1: img[r][c] = -(r * w + c) - 1;
          default: img[r][c] = $signed($urandom());
        endcase
    n_out = 0;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        if (stop >= 0 && n == stop) return;
        while (gap > 0 && $urandom_range(99) < gap) idle();
        trig = r[0] && c[0];
        px(sel, img[r][c], trig, trig ? gold(r, c) : 32'sd0,
           (r == h - 1) && (c == w - 1));
        n++;
      end
    end
    chk("n_out", n_out, (w / 2) * (h / 2));
    chk("sb_drained", sb_q.size(), 0);
  endtask

  initial begin
    #12;
    chk("rst_dout", dout_a, 0);
    chk("rst_vout", vout_a, 0);
    chk("rst_fdone", fd_a, 0);
    vin_a = 1'b1;
    @(posedge clk);
    #1;
    chk("vin_in_rst_vout", vout_a, 0);
    vin_a = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_frame(0, 24, 24, 0, 0, -1);
    run_frame(0, 24, 24, 1, 0, -1);
    run_frame(0, 24, 24, 0, 40, -1);
    run_frame(1, 5, 5, 0, 0, -1);
    run_frame(1, 5, 5, 0, 30, -1);

    run_frame(0, 24, 24, 0, 0, -1);
    run_frame(0, 24, 24, 0, 0, -1);
    run_frame(0, 24, 24, 0, 0, 100);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_dout", dout_a, 0);
    chk("mid_rst_vout", vout_a, 0);
    sb_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
    run_frame(0, 24, 24, 0, 0, -1);

    run_frame(0, 24, 24, 2, 0, -1);
    run_frame(0, 24, 24, 2, 25, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=1 exp=0");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/maxpool2x2_stream.md
Name: maxpool2x2_stream

Overview:
- Raster-stream 2x2 / stride-2 max-pool unit on the receive side of conv_accelerator's result stream.
- Consumes the result_ch0/result_valid pixel stream, one OUT_W x OUT_H feature map per frame, and emits a pooled (IN_W/2)x(IN_H/2) stream in raster order.
- Default geometry 24x24 -> 12x12 feeds the next CNN stage.
- No backpressure: the upstream producer has none.

Parameters:
- IN_W, 24, input feature-map width in pixels
- IN_H, 24, input feature-map height in pixels
- DATA_WIDTH, 32, signed sample width, same as conv OUT_WIDTH

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- valid_in  in  1  input sample strobe, one raster pixel per asserted cycle
- data_in  in  DATA_WIDTH  signed input sample
- data_out  out  DATA_WIDTH  signed pooled result, registered
- valid_out  out  1  one-cycle strobe qualifying data_out
- frame_done  out  1  one-cycle pulse on the cycle the last input pixel of a frame is accepted

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: data_out=0, valid_out=0, frame_done=0, col=0, row=0, pair register=0.
  - Line buffer contents are don't-care; every even row overwrites them before they are read.
- Counters:
  - col runs 0..IN_W-1 and row runs 0..IN_H-1. Both advance only on valid_in.
  - col wraps to 0 and increments row after col=IN_W-1.
  - row wraps to 0 after the last pixel (col=IN_W-1, row=IN_H-1).
  - A new frame starts on the next valid_in with no idle gap required.
- Gaps: idle cycles (valid_in=0) are legal anywhere. State holds and no output is produced.
- Horizontal stage:
  - On valid_in with col even, latch data_in into the pair register.
  - On valid_in with col odd, hmax = signed max(pair, data_in).
- Vertical stage:
  - Even row, odd col: write hmax to linebuf[col>>1]. Depth is IN_W/2.
  - Odd row, odd col: vmax = signed max(hmax, linebuf[col>>1]).
- Output timing: data_out<=vmax and valid_out<=1 on the clock edge that accepts that odd-row/odd-col input. Latency is therefore 1 cycle; valid_out is high in the cycle after the input cycle.
- Output rate:
  - At most one output per two accepted inputs.
  - Exactly (IN_W/2)*(IN_H/2) outputs per frame, in raster order.
  - data_out holds its last value when valid_out=0.
- Odd dimensions:
  - If IN_W is odd, the last column is ignored: no pair and no write.
  - If IN_H is odd, the last row is ignored: no output.
  - Floor semantics in both cases.
- Arithmetic: all compares are signed DATA_WIDTH. No widening, no saturation. On a tie, either operand is acceptable since the values are equal.
- frame_done: registered. Asserted in the cycle after the input at col=IN_W-1, row=IN_H-1 is accepted, so it coincides with the last valid_out when both dims are even.
- Reset mid-frame: asserting rst returns everything to the reset state immediately. The partial frame is discarded and the next accepted pixel is treated as (0,0).
- valid_in asserted during rst is ignored.

Decomposition:
- Package cnn_pkg holds:
  - the conv output geometry constants (CONV1_OUT_W=24, CONV1_OUT_H=24), from which IN_W/IN_H defaults are derived
  - the shared feature DATA_WIDTH=32
  - a signed max function used by both stages
- One sub-module is natural: pool_line_buf, a single-port IN_W/2 x DATA_WIDTH register array.
  - Write enable and index come from the parent.
  - Combinational read by index; read and write are never needed in the same cycle.

Test Plan:
- Ramp, IN_W=IN_H=24: feed data_in=row*24+col contiguously.
  - Exactly 144 valid_out.
  - Output k=(r,c) equals (2r+1)*24+2c+1; first=25, last=575.
  - frame_done is one pulse, aligned with output 143.
- Signed values: feed data_in = -(row*24+col) - 1.
  - Outputs equal -(2r*24+2c) - 1; first=-1, second=-3.
  - Proves signed compare, not unsigned.
- Random valid_in gaps (about 40% idle), same ramp.
  - Identical output sequence to the contiguous run.
  - Each valid_out exactly 1 cycle after its triggering input; no outputs during idle.
- Odd dims, IN_W=IN_H=5, ramp data_in=row*5+col.
  - Exactly 4 outputs: 6, 8, 16, 18.
  - Column 4 and row 4 are ignored; frame_done fires on pixel 24.
- Back-to-back frames then mid-frame reset.
  - Two ramp frames with no gap give 288 correct outputs.
  - rst pulsed after 100 pixels of frame 3: outputs drop to 0 and counters clear.
  - A fresh ramp frame then gives the 144 correct values.
- Conv chain: conv_accelerator output stream (image x*9+y*13, kernel 1..25) fed into this block.
  - Matches the software max-pool of the golden conv results: 144/144 correct.
